// File: rtl/fault_mem_pkg.sv
// Shared types for the fault-injecting memory generator: fault type codes and
// the fault slot record. Slot fields are sized for the widest supported memory.
package fault_mem_pkg;

    localparam int SLOT_ADDR_W = 16;
    localparam int SLOT_BIT_W  = 8;

    typedef enum logic [2:0] {
        FT_NONE  = 3'd0,
        FT_SA0   = 3'd1,
        FT_SA1   = 3'd2,
        FT_TF_UP = 3'd3,
        FT_TF_DN = 3'd4,
        FT_NPSF  = 3'd5
    } fault_type_e;

    typedef struct packed {
        logic [SLOT_ADDR_W-1:0] addr;
        fault_type_e            ftype;
        logic [SLOT_BIT_W-1:0]  bit_idx;
    } fault_slot_t;

    // Stuck-at faults are the only ones visible on the read path.
    function automatic logic is_stuck(fault_type_e t);
        return (t == FT_SA0) || (t == FT_SA1);
    endfunction

endpackage

// File: rtl/fault_mem_gen_fault_inject.sv
// Combinational per-word fault application: walks the slot list in ascending
// order, each slot acting on the previous result; hit flags any change.
module fault_inject
    import fault_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_FAULTS = 2
) (
    input  logic                  commit,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] old_word,
    input  logic [DATA_WIDTH-1:0] new_word,
    input  logic [DATA_WIDTH-1:0] nb_hi,
    input  logic [DATA_WIDTH-1:0] nb_lo,
    input  fault_slot_t           slots [NUM_FAULTS],
    output logic [DATA_WIDTH-1:0] faulted,
    output logic                  hit
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    always_comb begin
        logic [DATA_WIDTH-1:0] w;
        logic [BW-1:0]         b;
        w = new_word;
        b = '0;
        for (int i = 0; i < NUM_FAULTS; i++) begin
            if (slots[i].addr == SLOT_ADDR_W'(addr) &&
                int'(slots[i].bit_idx) < DATA_WIDTH &&
                (commit || is_stuck(slots[i].ftype))) begin
                b = slots[i].bit_idx[BW-1:0];
                case (slots[i].ftype)
                    FT_SA0:   w[b] = 1'b0;
                    FT_SA1:   w[b] = 1'b1;
                    FT_TF_UP: if (!old_word[b] && w[b]) w[b] = 1'b0;
                    FT_TF_DN: if (old_word[b] && !w[b]) w[b] = 1'b1;
                    FT_NPSF:  if (!nb_hi[b] && nb_lo[b]) w[b] = 1'b0;
                    default:  ;
                endcase
            end
        end
        faulted = w;
        hit     = (w != new_word);
    end

endmodule

// File: rtl/fault_mem_gen.sv
// Fault-injecting memory model with zeroing init sweep and 2-stage access pipe.
// Define FAULT_MEM_STATS_EN to build the saturating fault_hits counter.
//
//   state   | meaning
//   ST_INIT | writing 0 to one word per cycle, accesses ignored
//   ST_RUN  | ready = 1, reads/writes accepted every cycle
module fault_mem_gen
    import fault_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_FAULTS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_read,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    output logic                  ready,
    input  logic                  cfg_we,
    input  logic [((NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1)-1:0] cfg_slot,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [2:0]            cfg_type,
    input  logic [$clog2(DATA_WIDTH)-1:0] cfg_bit,
    output logic [15:0]           fault_hits
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e                state, state_nx;
    logic [ADDR_WIDTH-1:0] sweep_addr, sweep_addr_nx;
    logic                  init_we;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    fault_slot_t           slots [NUM_FAULTS];

    logic                  s1_valid, s1_wr;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [DATA_WIDTH-1:0] s1_wdata;
    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_data;

    logic [DATA_WIDTH-1:0] cur_word, nb_hi, nb_lo, inj_word;
    logic                  inj_hit;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            sweep_addr <= '0;
        end else begin
            state      <= state_nx;
            sweep_addr <= sweep_addr_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        sweep_addr_nx = sweep_addr;
        init_we       = 1'b0;
        case (state)
            ST_INIT: begin
                init_we = 1'b1;
                if (sweep_addr == '1) state_nx = ST_RUN;
                else                  sweep_addr_nx = sweep_addr + ADDR_WIDTH'(1);
            end
            ST_RUN:  ;
            default: state_nx = ST_INIT;
        endcase
    end

    assign ready = (state == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FAULTS; i++) begin
                slots[i].addr    <= '0;
                slots[i].ftype   <= FT_NONE;
                slots[i].bit_idx <= '0;
            end
        end else if (cfg_we && int'(cfg_slot) < NUM_FAULTS) begin
            slots[cfg_slot].addr    <= SLOT_ADDR_W'(cfg_addr);
            slots[cfg_slot].ftype   <= fault_type_e'(cfg_type);
            slots[cfg_slot].bit_idx <= SLOT_BIT_W'(cfg_bit);
        end
    end

    // Neighbours past either end of the array read as zero (no wrap).
    always_comb begin
        cur_word = mem[s1_addr];
        nb_hi    = '0;
        nb_lo    = '0;
        if (s1_addr != '1) nb_hi = mem[s1_addr + ADDR_WIDTH'(1)];
        if (s1_addr != '0) nb_lo = mem[s1_addr - ADDR_WIDTH'(1)];
    end

    fault_inject #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_FAULTS (NUM_FAULTS)
    ) u_inject (
        .commit   (s1_wr),
        .addr     (s1_addr),
        .old_word (cur_word),
        .new_word (s1_wr ? s1_wdata : cur_word),
        .nb_hi    (nb_hi),
        .nb_lo    (nb_lo),
        .slots    (slots),
        .faulted  (inj_word),
        .hit      (inj_hit)
    );

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = s1_addr;
        mem_wdata = inj_word;
        if (init_we) begin
            mem_we    = 1'b1;
            mem_waddr = sweep_addr;
            mem_wdata = '0;
        end else if (s1_valid && s1_wr) begin
            mem_we = 1'b1;
        end
    end

    // Array has no reset: contents survive rst_n until the sweep rewrites them.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_wr       <= 1'b0;
            s1_addr     <= '0;
            s1_wdata    <= '0;
            s2_valid    <= 1'b0;
            s2_data     <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            s1_valid <= ready;
            if (ready) begin
                s1_wr    <= write_read;
                s1_addr  <= address;
                s1_wdata <= wdata;
            end
            s2_valid <= s1_valid && !s1_wr;
            if (s1_valid && !s1_wr) s2_data <= inj_word;
            rdata_valid <= s2_valid;
            if (s2_valid) rdata <= s2_data;
        end
    end

`ifdef FAULT_MEM_STATS_EN
    // Fault-free shadow gives the reference for read-side activations.
    logic [DATA_WIDTH-1:0] shadow [DEPTH];
    logic [15:0]           hits_q;
    logic                  op_hit;

    always_ff @(posedge clk) begin
        if (mem_we) shadow[mem_waddr] <= init_we ? '0 : s1_wdata;
    end

    assign op_hit = s1_wr ? inj_hit : (inj_word != shadow[s1_addr]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hits_q <= '0;
        else if (s1_valid && op_hit && hits_q != 16'hFFFF)
            hits_q <= hits_q + 16'd1;
    end

    assign fault_hits = hits_q;
`else
    logic unused_hit;
    assign unused_hit = inj_hit;
    assign fault_hits = '0;
`endif

endmodule

// File: tb/tb_fault_mem_gen.sv
// Self-checking bench: array-level reference model with per-cycle compare,
// directed literal scenarios, then randomized accesses and fault configs.
module tb_fault_mem_gen;

    localparam int DEPTH = 16;
    localparam int NF    = 2;
`ifdef FAULT_MEM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       write_read = 1'b0;
    logic [3:0] address = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       ready;
    logic       cfg_we = 1'b0;
    logic [0:0] cfg_slot = '0;
    logic [3:0] cfg_addr = '0;
    logic [2:0] cfg_type = '0;
    logic [2:0] cfg_bit = '0;
    logic [15:0] fault_hits;

    int n_checks = 0;
    int n_fail   = 0;

    fault_mem_gen #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_FAULTS(NF)) dut (
        .clk(clk), .rst_n(rst_n), .write_read(write_read), .address(address),
        .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid), .ready(ready),
        .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_addr(cfg_addr),
        .cfg_type(cfg_type), .cfg_bit(cfg_bit), .fault_hits(fault_hits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_mem [DEPTH];
    logic [7:0] m_ff  [DEPTH];
    int         m_type [NF];
    int         m_addr [NF];
    int         m_bit  [NF];
    bit         m_ready, p_v, p_wr, r_v, m_valid;
    int         m_init, p_a, m_hits;
    logic [7:0] p_d, r_d, m_rdata, nv;

    function automatic logic [7:0] faulted(input bit commit, input int a, input logic [7:0] newv);
        logic [7:0] w;
        logic [7:0] oldw;
        bit hi, lo;
        w = newv;
        oldw = m_mem[a];
        for (int s = 0; s < NF; s++) begin
            if (m_addr[s] == a) begin
                int b;
                b  = m_bit[s];
                hi = 1'b0;
                lo = 1'b0;
                if (a + 1 < DEPTH) hi = m_mem[a + 1][b];
                if (a > 0)         lo = m_mem[a - 1][b];
                case (m_type[s])
                    1: w[b] = 1'b0;
                    2: w[b] = 1'b1;
                    3: if (commit && !oldw[b] && w[b]) w[b] = 1'b0;
                    4: if (commit && oldw[b] && !w[b]) w[b] = 1'b1;
                    5: if (commit && !hi && lo) w[b] = 1'b0;
                    default: ;
                endcase
            end
        end
        return w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready = 0; m_init = 0; p_v = 0; r_v = 0;
            m_valid = 0; m_rdata = '0; m_hits = 0;
            for (int s = 0; s < NF; s++) begin
                m_type[s] = 0; m_addr[s] = 0; m_bit[s] = 0;
            end
        end else begin
            m_valid = r_v;
            if (r_v) m_rdata = r_d;
            r_v = 0;
            if (p_v) begin
                if (p_wr) begin
                    nv = faulted(1'b1, p_a, p_d);
                    if (nv != p_d && m_hits < 65535) m_hits++;
                    m_mem[p_a] = nv;
                    m_ff[p_a]  = p_d;
                end else begin
                    nv = faulted(1'b0, p_a, m_mem[p_a]);
                    if (nv != m_ff[p_a] && m_hits < 65535) m_hits++;
                    r_v = 1; r_d = nv;
                end
            end
            if (cfg_we) begin
                m_type[int'(cfg_slot)] = int'(cfg_type);
                m_addr[int'(cfg_slot)] = int'(cfg_addr);
                m_bit[int'(cfg_slot)]  = int'(cfg_bit);
            end
            p_v = m_ready;
            if (m_ready) begin
                p_wr = write_read; p_a = int'(address); p_d = wdata;
            end
            if (!m_ready) begin
                m_init++;
                if (m_init == DEPTH) begin
                    m_ready = 1;
                    for (int i = 0; i < DEPTH; i++) begin
                        m_mem[i] = '0; m_ff[i] = '0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                chk("reset_outputs", {rdata, rdata_valid, ready, fault_hits}, '0);
            end else begin
                chk("ready", 32'(ready), 32'(m_ready));
                chk("rdata_valid", 32'(rdata_valid), 32'(m_valid));
                if (m_valid) chk("rdata", 32'(rdata), 32'(m_rdata));
                chk("fault_hits", 32'(fault_hits), STATS ? 32'(m_hits) : 32'd0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic op(input logic wr, input int a, input logic [7:0] d);
        write_read = wr; address = 4'(a); wdata = d;
        @(negedge clk);
    endtask

    task automatic cfg(input int slot, input int a, input int t, input int b);
        cfg_we = 1'b1; cfg_slot = 1'(slot); cfg_addr = 4'(a);
        cfg_type = 3'(t); cfg_bit = 3'(b);
        write_read = 1'b0; address = '0;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic read_check(input string name, input int a, input logic [7:0] exp);
        op(1'b0, a, 8'h00);
        op(1'b0, a, 8'h00);
        op(1'b0, a, 8'h00);
        chk({name, "_valid"}, 32'(rdata_valid), 32'd1);
        chk(name, 32'(rdata), 32'(exp));
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        write_read = 1'b0; address = '0;
        while (!ready && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    int cyc;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ready(cyc);
        chk("ready_latency", 32'(cyc), 32'd16);
        read_check("rd5_after_init", 5, 8'h00);

        cfg(0, 3, 2, 2);
        op(1'b1, 3, 8'h00);
        read_check("sa1_read", 3, 8'h04);
        chk("sa1_hits", 32'(fault_hits), STATS ? 32'(m_hits) : 32'd0);

        cfg(1, 7, 3, 0);
        op(1'b1, 7, 8'h00);
        op(1'b1, 7, 8'h01);
        read_check("tf_up_read", 7, 8'h00);

        cfg(0, 5, 5, 6);
        op(1'b1, 6, 8'h00);
        op(1'b1, 4, 8'h40);
        op(1'b1, 5, 8'hFF);
        read_check("npsf_active", 5, 8'hBF);
        op(1'b1, 4, 8'h00);
        op(1'b1, 5, 8'hFF);
        read_check("npsf_inactive", 5, 8'hFF);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) op(1'b1, 2, 8'hAA);
        rst_n = 1'b0;
        #1;
        chk("ready_in_reset", 32'(ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(cyc);
        chk("ready_latency_restart", 32'(cyc), 32'd16);
        read_check("init_write_ignored", 2, 8'h00);
        op(1'b1, 4, 8'h40);
        op(1'b1, 6, 8'h00);
        op(1'b1, 5, 8'hFF);
        read_check("slots_cleared", 5, 8'hFF);

        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
            cfg_we   = ($urandom_range(0, 9) == 0);
            cfg_slot = 1'($urandom_range(0, 1));
            cfg_addr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(3, 7));
            cfg_type = 3'($urandom_range(0, 7));
            cfg_bit  = 3'($urandom_range(0, 7));
            write_read = 1'($urandom_range(0, 1));
            address  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(3, 7));
            wdata    = 8'($urandom);
            @(negedge clk);
        end
        cfg_we = 1'b0;
        write_read = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fault_mem_gen.md
FAULT_MEM_GEN -- requirements
Module: fault_mem_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits (>=8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 4; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter NUM_FAULTS, default 2, number of independent fault slots (1..8).
REQ-004 SHALL have ports as follows; one clock; reset is asynchronous and active-low.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- write_read  in  1  1 = write, 0 = read; sampled every cycle while ready = 1.
- address  in  ADDR_WIDTH  access address.
- wdata  in  DATA_WIDTH  write data.
- rdata  out  DATA_WIDTH  read data.
- rdata_valid  out  1  rdata holds a fresh read result this cycle.
- ready  out  1  initialisation sweep complete; accesses accepted.
- cfg_we  in  1  load one fault slot.
- cfg_slot  in  $clog2(NUM_FAULTS) (min 1)  slot index.
- cfg_addr  in  ADDR_WIDTH  victim address.
- cfg_type  in  3  fault type code.
- cfg_bit  in  $clog2(DATA_WIDTH)  victim bit index.
- fault_hits  out  16  count of fault activations.

Function
REQ-005 SHALL have two states: INIT (write 0 to address 0..DEPTH-1, one word per cycle) and RUN. After INIT sweeps DEPTH-1 it SHALL go to RUN and set ready = 1 on the next cycle.
REQ-006 SHALL ignore write_read, address and wdata while ready = 0: no array change and no rdata_valid.
REQ-007 SHALL use a two-stage pipeline. Edge N registers {write_read, address, wdata}. Edge N+1 executes: a write commits, or a read captures the array word. Edge N+2 drives rdata with rdata_valid = 1 for one cycle.
REQ-008 SHALL let a read issued one cycle after a write to the same address return the new data, with no forwarding required.
REQ-009 SHALL support these fault type codes: 0 NONE; 1 SA0 (victim bit forced 0); 2 SA1 (forced 1); 3 TF_UP (stored bit cannot go 0->1); 4 TF_DN (cannot go 1->0); 5 NPSF (on write, victim bit forced 0 when word[addr+1][bit] == 0 and word[addr-1][bit] == 1); 6..7 reserved, treated as NONE.
REQ-010 SHALL apply SA0/SA1 both on commit and on read output of the victim word; SHALL apply TF and NPSF only on commit.
REQ-011 SHALL treat an NPSF neighbour outside 0..DEPTH-1 as 0, with no wrap-around.
REQ-012 SHALL apply multiple active slots on the same address in ascending slot order, each slot acting on the previous result.
REQ-013 SHALL make a slot loaded by cfg_we at edge N effective for operations executed at edge N+1 or later; cfg_we SHALL be accepted in INIT and RUN.
REQ-014 SHALL count a fault activation when a slot changes the committed or read-out value versus the fault-free value, counting one per operation even if several slots change it.

Reset
REQ-015 SHALL, while rst_n = 0, drive rdata = 0, rdata_valid = 0, ready = 0, fault_hits = 0, all slots NONE, pipeline empty, state INIT with sweep address 0.
REQ-016 SHALL restart the INIT sweep from address 0 when reset is asserted mid-INIT or mid-RUN; array contents are not cleared by reset itself.

Configuration
REQ-017 With macro FAULT_MEM_STATS_EN defined, fault_hits SHALL count activations and saturate at 0xFFFF.
REQ-018 Without FAULT_MEM_STATS_EN, fault_hits SHALL be constant 0 and no counter logic SHALL exist.

Structure
REQ-019 Package fault_mem_pkg SHALL hold the fault type enum (codes per REQ-009) and the fault slot struct {addr, type, bit}.
REQ-020 Per-word fault application SHALL be a combinational sub-module fault_inject: inputs are old word, new word, neighbour bits and slot list; outputs are the faulted word and a hit flag.

Verification (DATA_WIDTH=8, ADDR_WIDTH=4, NUM_FAULTS=2)
REQ-021 Release reset, then read address 5 -> ready rises 16-17 cycles after release; rdata = 0x00.
REQ-022 Slot0 SA1, addr 3, bit 2; write 0x00 to 3, then read 3 -> rdata = 0x04 two edges after read issue; fault_hits = 2 (write and read) with macro, 0 without.
REQ-023 Slot1 TF_UP, addr 7, bit 0; write 0x00 then 0x01 to 7; read -> 0x00.
REQ-024 Slot0 NPSF, addr 5, bit 6; mem[6] = 0x00, mem[4] = 0x40; write 0xFF to 5; read -> 0xBF. Repeat with mem[4] = 0x00 -> 0xFF.
REQ-025 Assert rst_n low at cycle 8 of INIT, then release -> ready = 0 until 16 cycles later; all slots NONE; earlier writes to addr 2 of 0xAA during INIT read back 0x00.
